// File: rtl/useq_pkg.sv
// Shared definitions for the microcode sequencer: sequencing opcodes,
// FSM states and control-word field layout helpers.
package useq_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NEXT = 3'd0,
    OP_JUMP = 3'd1,
    OP_MAP  = 3'd2,
    OP_BRT  = 3'd3,
    OP_BRF  = 3'd4,
    OP_CALL = 3'd5,
    OP_RET  = 3'd6,
    OP_HALT = 3'd7
  } seq_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Word layout, MSB to LSB: next_addr | seq_op | cond_sel | ctrl
  function automatic int csel_lsb(int ctrl_w);
    return ctrl_w;
  endfunction

  function automatic int op_lsb(int ctrl_w, int ncond);
    return ctrl_w + $clog2(ncond);
  endfunction

  function automatic int na_lsb(int ctrl_w, int ncond);
    return ctrl_w + $clog2(ncond) + OP_W;
  endfunction

  function automatic int word_w(int uaddr_w, int ncond, int ctrl_w);
    return uaddr_w + OP_W + $clog2(ncond) + ctrl_w;
  endfunction

endpackage

// File: rtl/useq_stack.sv
// Micro-return stack: LIFO of return addresses with full/empty flags.
// Push while full and pop while empty are dropped; the sequencer
// treats those cases as faults before they reach here.
module useq_stack #(
  parameter int STK_D   = 2,
  parameter int UADDR_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               push,
  input  logic               pop,
  input  logic [UADDR_W-1:0] din,
  output logic [UADDR_W-1:0] top,
  output logic               full,
  output logic               empty
);

  localparam int SP_W = $clog2(STK_D + 1);

  // Sized to the full pointer range so sp indexes it without truncation
  logic [UADDR_W-1:0] mem [2**SP_W];
  logic [SP_W-1:0]    sp;

  assign full  = (sp == SP_W'(STK_D));
  assign empty = (sp == '0);
  assign top   = mem[sp - SP_W'(1)];

  // Stack pointer: cleared on reset or on a fresh start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              sp <= '0;
    else if (clr)            sp <= '0;
    else if (push && !full)  sp <= sp + SP_W'(1);
    else if (pop && !empty)  sp <= sp - SP_W'(1);
  end

  // Return-address storage, no reset needed
  always_ff @(posedge clk) begin
    if (!clr && push && !full) mem[sp] <= din;
  end

endmodule

// File: rtl/microcode_sequencer.sv
// Microcode sequencer: fetches a control word from a writable control
// store every RUN cycle, registers its ctrl field and computes the next
// micro-address from the word's sequencing op.
module microcode_sequencer
  import useq_pkg::*;
#(
  parameter  int UADDR_W = 6,
  parameter  int DEPTH   = 64,
  parameter  int CTRL_W  = 32,
  parameter  int NCOND   = 4,
  parameter  int STK_D   = 2,
  localparam int WORD_W  = word_w(UADDR_W, NCOND, CTRL_W)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stall,
  input  logic [UADDR_W-1:0] opcode,
  input  logic [NCOND-1:0]   cond,
  input  logic               rom_we,
  input  logic [UADDR_W-1:0] rom_waddr,
  input  logic [WORD_W-1:0]  rom_wdata,
  output logic [CTRL_W-1:0]  ctrl_out,
  output logic [UADDR_W-1:0] upc,
  output logic               finish,
  output logic               error
);

  localparam int CSEL_W   = $clog2(NCOND);
  localparam int RA_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CSEL_LSB = csel_lsb(CTRL_W);
  localparam int OP_LSB   = op_lsb(CTRL_W, NCOND);
  localparam int NA_LSB   = na_lsb(CTRL_W, NCOND);

  logic [WORD_W-1:0]  rom [DEPTH];
  state_e             state, state_nxt;
  logic [WORD_W-1:0]  word;
  seq_op_e            op;
  logic [UADDR_W-1:0] na, upc_inc, upc_nxt, stk_top;
  logic [CSEL_W-1:0]  csel;
  logic [CTRL_W-1:0]  ctrl_nxt;
  logic               c, exec, halt, fault, full, empty;
  logic               push, pop, clr, fin_nxt, err_nxt;

  // Addresses past DEPTH read as an all-zero word (NEXT, ctrl=0)
  assign word    = (int'(upc) < DEPTH) ? rom[upc[RA_W-1:0]] : '0;
  assign op      = seq_op_e'(word[OP_LSB +: OP_W]);
  assign na      = word[NA_LSB +: UADDR_W];
  assign csel    = word[CSEL_LSB +: CSEL_W];
  assign c       = cond[csel];
  assign upc_inc = upc + 1'b1;
  assign exec    = (state == ST_RUN) && !stall;
  assign halt    = exec && (op == OP_HALT);
  assign fault   = exec && (((op == OP_CALL) && full) || ((op == OP_RET) && empty));
  assign push    = exec && (op == OP_CALL) && !full;
  assign pop     = exec && (op == OP_RET) && !empty;
  assign clr     = (state != ST_RUN) && start;

  // Control-store load; RUN-time writes are dropped. A write in the same
  // cycle as start lands before the first fetch.
  always_ff @(posedge clk) begin
    if (rom_we && (state != ST_RUN) && (int'(rom_waddr) < DEPTH))
      rom[rom_waddr[RA_W-1:0]] <= rom_wdata;
  end

  useq_stack #(.STK_D(STK_D), .UADDR_W(UADDR_W)) u_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .din   (upc_inc),
    .top   (stk_top),
    .full  (full),
    .empty (empty)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_RUN;
      ST_RUN:  if (halt || fault) state_nxt = ST_DONE;
      ST_DONE: if (start) state_nxt = ST_RUN;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath next values; the edge entering DONE already loads ctrl=0
  always_comb begin
    upc_nxt  = upc;
    ctrl_nxt = ctrl_out;
    fin_nxt  = finish;
    err_nxt  = error;
    if (state != ST_RUN) begin
      ctrl_nxt = '0;
      if (start) begin
        upc_nxt = '0;
        fin_nxt = 1'b0;
        err_nxt = 1'b0;
      end
    end else if (!stall) begin
      ctrl_nxt = word[CTRL_W-1:0];
      case (op)
        OP_NEXT: upc_nxt = upc_inc;
        OP_JUMP: upc_nxt = na;
        OP_MAP:  upc_nxt = opcode;
        OP_BRT:  upc_nxt = c ? na : upc_inc;
        OP_BRF:  upc_nxt = c ? upc_inc : na;
        OP_CALL: if (!full) upc_nxt = na;
        OP_RET:  if (!empty) upc_nxt = stk_top;
        OP_HALT: begin
          fin_nxt  = 1'b1;
          ctrl_nxt = '0;
        end
        default: upc_nxt = upc_inc;
      endcase
      if (fault) begin
        err_nxt  = 1'b1;
        ctrl_nxt = '0;
      end
    end
  end

  // Output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upc      <= '0;
      ctrl_out <= '0;
      finish   <= 1'b0;
      error    <= 1'b0;
    end else begin
      upc      <= upc_nxt;
      ctrl_out <= ctrl_nxt;
      finish   <= fin_nxt;
      error    <= err_nxt;
    end
  end

endmodule

// File: tb/tb_microcode_sequencer.sv
// Bench for microcode_sequencer: directed programs plus randomized runs,
// all checked cycle by cycle against a behavioural model.
module tb_microcode_sequencer;

  localparam int UADDR_W = 6;
  localparam int DEPTH   = 64;
  localparam int CTRL_W  = 32;
  localparam int NCOND   = 4;
  localparam int STK_D   = 2;
  localparam int WORD_W  = 43;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start, stall, rom_we;
  logic [UADDR_W-1:0] opcode, rom_waddr;
  logic [NCOND-1:0]   cond;
  logic [WORD_W-1:0]  rom_wdata;
  logic [CTRL_W-1:0]  ctrl_out;
  logic [UADDR_W-1:0] upc;
  logic               finish, error;

  int n_chk = 0;
  int n_fail = 0;

  // Behavioural model state
  logic [WORD_W-1:0] m_rom [DEPTH];
  bit                m_run, m_fin, m_err;
  int                m_upc;
  logic [31:0]       m_ctrl;
  int                m_stk[$];

  microcode_sequencer #(
    .UADDR_W(UADDR_W), .DEPTH(DEPTH), .CTRL_W(CTRL_W), .NCOND(NCOND), .STK_D(STK_D)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall), .opcode(opcode),
    .cond(cond), .rom_we(rom_we), .rom_waddr(rom_waddr), .rom_wdata(rom_wdata),
    .ctrl_out(ctrl_out), .upc(upc), .finish(finish), .error(error)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, longint act, longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [WORD_W-1:0] mk(int op, int na, int cs, logic [31:0] ctrl);
    return {6'(na), 3'(op), 2'(cs), ctrl};
  endfunction

  task automatic model_reset();
    m_run = 0; m_fin = 0; m_err = 0; m_upc = 0; m_ctrl = 0;
    m_stk.delete();
  endtask

  task automatic model_fault();
    m_err = 1; m_ctrl = 0; m_run = 0;
  endtask

  // One clock of the sequencer described at the instruction level
  task automatic model_step();
    logic [WORD_W-1:0] w;
    int op, na, cs, nxt;
    if (!m_run) begin
      if (rom_we) m_rom[rom_waddr] = rom_wdata;
      m_ctrl = 0;
      if (start) begin
        m_run = 1; m_upc = 0; m_fin = 0; m_err = 0;
        m_stk.delete();
      end
    end else if (!stall) begin
      w      = (m_upc < DEPTH) ? m_rom[m_upc] : '0;
      m_ctrl = w[31:0];
      cs     = int'(w[33:32]);
      op     = int'(w[36:34]);
      na     = int'(w[42:37]);
      nxt    = (m_upc + 1) % 64;
      case (op)
        0: m_upc = nxt;
        1: m_upc = na;
        2: m_upc = int'(opcode);
        3: m_upc = cond[cs] ? na : nxt;
        4: m_upc = cond[cs] ? nxt : na;
        5: if (m_stk.size() == STK_D) model_fault();
           else begin m_stk.push_back(nxt); m_upc = na; end
        6: if (m_stk.size() == 0) model_fault();
           else m_upc = m_stk.pop_back();
        default: begin m_fin = 1; m_ctrl = 0; m_run = 0; end
      endcase
    end
  endtask

  task automatic compare();
    chk("upc", upc, m_upc);
    chk("ctrl_out", ctrl_out, m_ctrl);
    chk("finish", finish, m_fin);
    chk("error", error, m_err);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare();
  endtask

  task automatic load(int a, logic [WORD_W-1:0] w);
    rom_we = 1; rom_waddr = 6'(a); rom_wdata = w;
    cycle();
    rom_we = 0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < DEPTH; i++) load(i, '0);
  endtask

  task automatic kick();
    start = 1;
    cycle();
    start = 0;
  endtask

  // Asynchronous reset pulse between clock edges
  task automatic do_reset();
    #2 rst_n = 0;
    #1;
    model_reset();
    chk("rst_upc", upc, 0);
    chk("rst_ctrl", ctrl_out, 0);
    chk("rst_flags", {finish, error}, 0);
    compare();
    #1 rst_n = 1;
  endtask

  initial begin
    rst_n = 0; start = 0; stall = 0; rom_we = 0; opcode = 0; cond = 0;
    rom_waddr = 0; rom_wdata = 0;
    for (int i = 0; i < DEPTH; i++) m_rom[i] = '0;
    model_reset();
    @(negedge clk);
    chk("reset_upc", upc, 0);
    chk("reset_ctrl", ctrl_out, 0);
    chk("reset_flags", {finish, error}, 0);
    rst_n = 1;

    // Basic NEXT / JUMP / HALT program
    clear_rom();
    load(0, mk(0, 0, 0, 32'h11));
    load(1, mk(1, 5, 0, 32'h22));
    load(5, mk(7, 0, 0, 32'h0));
    kick();
    chk("p1_start_upc", upc, 0);
    cycle(); chk("p1_ctrl0", ctrl_out, 32'h11); chk("p1_upc1", upc, 1);
    cycle(); chk("p1_ctrl1", ctrl_out, 32'h22); chk("p1_upc5", upc, 5);
    cycle(); chk("p1_ctrl5", ctrl_out, 0); chk("p1_fin", finish, 1); chk("p1_halt_upc", upc, 5);

    // MAP and BRT; ROM[0] written in the same cycle as start
    clear_rom();
    load(42, mk(3, 48, 0, 32'h2));
    load(43, mk(7, 0, 0, 0));
    load(48, mk(7, 0, 0, 0));
    opcode = 6'h2A; cond = 4'b1110;
    rom_we = 1; rom_waddr = 0; rom_wdata = mk(2, 0, 0, 32'h1);
    kick();
    rom_we = 0;
    cycle(); chk("map_upc", upc, 6'h2A); chk("map_ctrl", ctrl_out, 1);
    cycle(); chk("brt_nt_upc", upc, 6'h2B);
    cycle(); chk("brt_nt_fin", finish, 1);
    cond = 4'b0001;
    kick(); cycle(); cycle(); chk("brt_t_upc", upc, 6'h30);

    // CALL / RET and stack overflow
    clear_rom();
    load(0, mk(1, 3, 0, 32'hA0));
    load(3, mk(5, 10, 0, 32'hA3));
    load(10, mk(6, 0, 0, 32'hAA));
    load(4, mk(5, 20, 0, 32'hA4));
    load(20, mk(5, 21, 0, 32'hB4));
    load(21, mk(5, 22, 0, 32'hB5));
    kick(); cycle(); cycle();
    chk("call_upc", upc, 10);
    cycle(); chk("ret_upc", upc, 4);
    cycle(); cycle(); cycle();
    chk("ovf_err", error, 1); chk("ovf_upc", upc, 21); chk("ovf_fin", finish, 0);
    cycle(); chk("done_upc_hold", upc, 21); chk("done_ctrl", ctrl_out, 0);

    // Stall, RUN-time write ignored, DONE-time write honoured
    clear_rom();
    for (int i = 0; i < 8; i++) load(i, mk(0, 0, 0, 32'(i + 1)));
    load(8, mk(7, 0, 0, 0));
    kick(); cycle(); cycle();
    chk("pre_stall_upc", upc, 2);
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      cycle(); chk("stall_upc", upc, 2); chk("stall_ctrl", ctrl_out, 2);
    end
    stall = 0;
    cycle(); chk("resume_upc", upc, 3); chk("resume_ctrl", ctrl_out, 3);
    rom_we = 1; rom_waddr = 8; rom_wdata = mk(0, 0, 0, 32'h99);
    cycle(); rom_we = 0;
    for (int i = 0; i < 5; i++) cycle();
    chk("run_we_ignored_fin", finish, 1); chk("run_we_ignored_upc", upc, 8);
    load(8, mk(0, 0, 0, 32'h99));
    kick();
    for (int i = 0; i < 9; i++) cycle();
    chk("done_we_ctrl", ctrl_out, 32'h99); chk("done_we_upc", upc, 9);

    // Asynchronous reset mid-RUN, then re-run from 0
    do_reset();
    kick(); cycle(); cycle(); cycle();
    chk("rerun_ctrl", ctrl_out, 3); chk("rerun_upc", upc, 3);

    // Randomized programs and inputs
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int i = 0; i < DEPTH; i++)
        load(i, mk($urandom_range(0, 7), $urandom_range(0, 63), $urandom_range(0, 3), $urandom));
      for (int k = 0; k < 300; k++) begin
        start     = ($urandom_range(0, 3) == 0);
        stall     = ($urandom_range(0, 3) == 0);
        cond      = 4'($urandom_range(0, 15));
        opcode    = 6'($urandom_range(0, 63));
        rom_we    = ($urandom_range(0, 7) == 0);
        rom_waddr = 6'($urandom_range(0, 63));
        rom_wdata = mk($urandom_range(0, 7), $urandom_range(0, 63), $urandom_range(0, 3), $urandom);
        if ($urandom_range(0, 99) == 0) do_reset();
        cycle();
      end
      start = 0; stall = 0; rom_we = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
